// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hold/redirect controller with JTAG halt/drain and reset stretch
// Merges execute/trap redirects and stalls, and replays redirects the PC register would drop under hold.
module pipe_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DRAIN_CYC = 3,
  parameter int JRST_CYC  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ex_jump_flag_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic              ex_hold_i,
  input  logic              bus_hold_i,
  input  logic              int_req_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  output logic              int_ack_o,
  input  logic              jtag_halt_req_i,
  output logic              jtag_halted_o,
  input  logic              jtag_reset_i,
  output logic [2:0]        hold_flag_o,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              flush_o,
  output logic              jtag_reset_flag_o
);

  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam int JW = $clog2(JRST_CYC + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);
  localparam logic [JW-1:0] JRST_LOAD  = JW'(JRST_CYC);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       drain_cnt_q, drain_cnt_d;
  logic [JW-1:0]       jrst_cnt_q, jrst_cnt_d;
  logic                pend_v_q, pend_v_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                halted_q, halted_d;

  logic                rst_stretch;
  logic [2:0]          hold;
  logic                ack;
  logic                cand_v;
  logic [ADDR_W-1:0]   cand_addr;
  logic                jump;
  logic [ADDR_W-1:0]   jump_addr;
  logic                flush;
  logic                drain_done;

  always_comb begin
    rst_stretch = (jrst_cnt_q != '0);
    drain_done  = (drain_cnt_q == DRAIN_LAST);

    hold = 3'b000;
    if (state_q == HALTED || ex_hold_i || rst_stretch) hold = 3'b111;
    if (bus_hold_i)       hold = hold | 3'b011;
    if (state_q == DRAIN) hold = hold | 3'b001;

    ack = (state_q == RUN) && !pend_v_q && !rst_stretch && int_req_i;

    // A pending redirect makes any execute jump wrong-path; an acked trap owns the cycle.
    cand_v    = 1'b0;
    cand_addr = '0;
    if (!rst_stretch) begin
      if (pend_v_q) begin
        cand_v    = 1'b1;
        cand_addr = pend_addr_q;
      end else if (ack) begin
        cand_v    = 1'b1;
        cand_addr = int_addr_i;
      end else if (ex_jump_flag_i) begin
        cand_v    = 1'b1;
        cand_addr = ex_jump_addr_i;
      end
    end

    jump        = 1'b0;
    jump_addr   = '0;
    flush       = 1'b0;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    if (cand_v) begin
      if (hold == 3'b000) begin
        jump      = 1'b1;
        jump_addr = cand_addr;
        flush     = 1'b1;
        pend_v_d  = 1'b0;
      end else if (!pend_v_q) begin
        flush       = 1'b1;
        pend_v_d    = 1'b1;
        pend_addr_d = cand_addr;
      end
    end
    if (jtag_reset_i || rst_stretch) pend_v_d = 1'b0;

    state_d = state_q;
    case (state_q)
      RUN:    if (jtag_halt_req_i) state_d = DRAIN;
      DRAIN: begin
        if (!jtag_halt_req_i) state_d = RUN;
        else if (drain_done && !ex_hold_i && !bus_hold_i) state_d = HALTED;
      end
      HALTED: if (!jtag_halt_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (jtag_reset_i || rst_stretch) state_d = RUN;

    // Counts DRAIN cycles already completed; saturates once the minimum is met.
    drain_cnt_d = '0;
    if (state_q == DRAIN && state_d == DRAIN)
      drain_cnt_d = drain_done ? drain_cnt_q : drain_cnt_q + DW'(1);

    jrst_cnt_d = jrst_cnt_q;
    if (jtag_reset_i)     jrst_cnt_d = JRST_LOAD;
    else if (rst_stretch) jrst_cnt_d = jrst_cnt_q - JW'(1);

    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
      jrst_cnt_q  <= '0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      jrst_cnt_q  <= jrst_cnt_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      halted_q    <= halted_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign hold_flag_o       = rst_n_i ? hold : 3'b000;
  assign jump_flag_o       = rst_n_i & jump;
  assign jump_addr_o       = rst_n_i ? jump_addr : '0;
  assign flush_o           = rst_n_i & flush;
  assign int_ack_o         = rst_n_i & ack;
  assign jtag_halted_o     = halted_q;
  assign jtag_reset_flag_o = rst_stretch;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
// Inputs change at the falling edge; outputs are sampled 1ns later.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_jump_flag;
  logic [31:0] ex_jump_addr;
  logic        ex_hold;
  logic        bus_hold;
  logic        int_req;
  logic [31:0] int_addr;
  logic        int_ack;
  logic        halt_req;
  logic        halted;
  logic        jtag_reset;
  logic [2:0]  hold_flag;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        flush;
  logic        jrst_flag;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(32), .DRAIN_CYC(3), .JRST_CYC(4)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .ex_jump_flag_i   (ex_jump_flag),
    .ex_jump_addr_i   (ex_jump_addr),
    .ex_hold_i        (ex_hold),
    .bus_hold_i       (bus_hold),
    .int_req_i        (int_req),
    .int_addr_i       (int_addr),
    .int_ack_o        (int_ack),
    .jtag_halt_req_i  (halt_req),
    .jtag_halted_o    (halted),
    .jtag_reset_i     (jtag_reset),
    .hold_flag_o      (hold_flag),
    .jump_flag_o      (jump_flag),
    .jump_addr_o      (jump_addr),
    .flush_o          (flush),
    .jtag_reset_flag_o(jrst_flag)
  );

  task automatic idle_inputs();
    ex_jump_flag = 1'b0;
    ex_jump_addr = 32'h0;
    ex_hold      = 1'b0;
    bus_hold     = 1'b0;
    int_req      = 1'b0;
    int_addr     = 32'h0;
    halt_req     = 1'b0;
    jtag_reset   = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    ex_jump_flag = 1'b1; ex_jump_addr = 32'h44; ex_hold = 1'b1; int_req = 1'b1;
    next_cycle(); #1;
    checks++; if (hold_flag !== 3'b000) begin errors++; $display("FAIL reset_hold got=%b exp=000", hold_flag); end
    checks++; if (jump_flag !== 1'b0) begin errors++; $display("FAIL reset_jump got=%b exp=0", jump_flag); end
    checks++; if (jump_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", jump_addr); end
    checks++; if (flush !== 1'b0 || int_ack !== 1'b0) begin errors++; $display("FAIL reset_flush_ack got=%b%b exp=00", flush, int_ack); end
    checks++; if (halted !== 1'b0 || jrst_flag !== 1'b0) begin errors++; $display("FAIL reset_regs got=%b%b exp=00", halted, jrst_flag); end
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_jump();
    ex_jump_flag = 1'b1; ex_jump_addr = 32'h100;
    #1;
    checks++; if (jump_flag !== 1'b1 || jump_addr !== 32'h100) begin errors++; $display("FAIL jump_issue got=%b/%h exp=1/100", jump_flag, jump_addr); end
    checks++; if (flush !== 1'b1 || hold_flag !== 3'b000) begin errors++; $display("FAIL jump_flush_hold got=%b/%b exp=1/000", flush, hold_flag); end
    next_cycle();
    idle_inputs(); #1;
    checks++; if (jump_flag !== 1'b0 || jump_addr !== 32'h0) begin errors++; $display("FAIL jump_idle got=%b/%h exp=0/0", jump_flag, jump_addr); end
    next_cycle();
  endtask

  task automatic test_hold_replay();
    ex_hold = 1'b1; ex_jump_flag = 1'b1; ex_jump_addr = 32'h200;
    #1;
    checks++; if (hold_flag !== 3'b111 || flush !== 1'b1 || jump_flag !== 1'b0) begin errors++; $display("FAIL hold_latch got=%b/%b/%b exp=111/1/0", hold_flag, flush, jump_flag); end
    next_cycle();
    ex_jump_addr = 32'h300; #1;
    checks++; if (flush !== 1'b0 || jump_flag !== 1'b0) begin errors++; $display("FAIL hold_second_jump got=%b/%b exp=0/0", flush, jump_flag); end
    next_cycle();
    ex_jump_flag = 1'b0; ex_jump_addr = 32'h0; #1;
    checks++; if (hold_flag !== 3'b111 || jump_flag !== 1'b0) begin errors++; $display("FAIL hold_third got=%b/%b exp=111/0", hold_flag, jump_flag); end
    next_cycle();
    ex_hold = 1'b0; #1;
    checks++; if (jump_flag !== 1'b1 || jump_addr !== 32'h200 || flush !== 1'b1) begin errors++; $display("FAIL hold_replay got=%b/%h/%b exp=1/200/1", jump_flag, jump_addr, flush); end
    next_cycle(); #1;
    checks++; if (jump_flag !== 1'b0) begin errors++; $display("FAIL hold_after_replay got=%b exp=0", jump_flag); end
    next_cycle();
  endtask

  task automatic test_int_vs_jump();
    int_req = 1'b1; int_addr = 32'h80; ex_jump_flag = 1'b1; ex_jump_addr = 32'h400;
    #1;
    checks++; if (int_ack !== 1'b1 || jump_flag !== 1'b1 || jump_addr !== 32'h80) begin errors++; $display("FAIL int_prio got=%b/%b/%h exp=1/1/80", int_ack, jump_flag, jump_addr); end
    next_cycle();
    idle_inputs(); #1;
    checks++; if (jump_flag !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL int_drop_ex got=%b/%b exp=0/0", jump_flag, flush); end
    next_cycle();
  endtask

  task automatic test_halt_drain();
    halt_req = 1'b1; bus_hold = 1'b1; #1;
    checks++; if (hold_flag !== 3'b011) begin errors++; $display("FAIL halt_run_bus got=%b exp=011", hold_flag); end
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      if (i == 2) begin int_req = 1'b1; int_addr = 32'h90; end
      #1;
      checks++; if (hold_flag !== 3'b011 || halted !== 1'b0 || int_ack !== 1'b0) begin errors++; $display("FAIL halt_drain_bus%0d got=%b/%b/%b exp=011/0/0", i, hold_flag, halted, int_ack); end
    end
    next_cycle();
    bus_hold = 1'b0; #1;
    checks++; if (hold_flag !== 3'b001 || halted !== 1'b0 || int_ack !== 1'b0) begin errors++; $display("FAIL halt_drain_free got=%b/%b/%b exp=001/0/0", hold_flag, halted, int_ack); end
    next_cycle(); #1;
    checks++; if (halted !== 1'b1 || hold_flag !== 3'b111 || int_ack !== 1'b0) begin errors++; $display("FAIL halt_halted got=%b/%b/%b exp=1/111/0", halted, hold_flag, int_ack); end
    next_cycle();
    halt_req = 1'b0; #1;
    checks++; if (halted !== 1'b1 || int_ack !== 1'b0) begin errors++; $display("FAIL halt_release_cycle got=%b/%b exp=1/0", halted, int_ack); end
    next_cycle(); #1;
    checks++; if (halted !== 1'b0 || int_ack !== 1'b1 || jump_flag !== 1'b1 || jump_addr !== 32'h90) begin errors++; $display("FAIL halt_resume_ack got=%b/%b/%b/%h exp=0/1/1/90", halted, int_ack, jump_flag, jump_addr); end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_jtag_reset();
    halt_req = 1'b1; #1;
    checks++; if (hold_flag !== 3'b000) begin errors++; $display("FAIL jr_run got=%b exp=000", hold_flag); end
    next_cycle(); next_cycle(); next_cycle(); #1;
    checks++; if (halted !== 1'b0 || hold_flag !== 3'b001) begin errors++; $display("FAIL jr_drain_last got=%b/%b exp=0/001", halted, hold_flag); end
    next_cycle();
    ex_jump_flag = 1'b1; ex_jump_addr = 32'h500; #1;
    checks++; if (halted !== 1'b1 || flush !== 1'b1 || jump_flag !== 1'b0) begin errors++; $display("FAIL jr_halted_latch got=%b/%b/%b exp=1/1/0", halted, flush, jump_flag); end
    next_cycle();
    ex_jump_flag = 1'b0; ex_jump_addr = 32'h0; halt_req = 1'b0; jtag_reset = 1'b1; #1;
    checks++; if (jrst_flag !== 1'b0 || jump_flag !== 1'b0) begin errors++; $display("FAIL jr_pulse_cycle got=%b/%b exp=0/0", jrst_flag, jump_flag); end
    next_cycle();
    jtag_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (jrst_flag !== 1'b1 || hold_flag !== 3'b111 || jump_flag !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL jr_stretch%0d got=%b/%b/%b/%b exp=1/111/0/0", i, jrst_flag, hold_flag, jump_flag, halted); end
      next_cycle();
    end
    #1;
    checks++; if (jrst_flag !== 1'b0 || hold_flag !== 3'b000 || jump_flag !== 1'b0) begin errors++; $display("FAIL jr_after got=%b/%b/%b exp=0/000/0", jrst_flag, hold_flag, jump_flag); end
    next_cycle(); #1;
    checks++; if (jump_flag !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL jr_after2 got=%b/%b exp=0/0", jump_flag, halted); end
    next_cycle();
  endtask

  task automatic test_async_reset();
    ex_hold = 1'b1; ex_jump_flag = 1'b1; ex_jump_addr = 32'h600; #1;
    checks++; if (flush !== 1'b1 || hold_flag !== 3'b111) begin errors++; $display("FAIL ar_latch got=%b/%b exp=1/111", flush, hold_flag); end
    next_cycle();
    ex_jump_flag = 1'b0; ex_jump_addr = 32'h0;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (hold_flag !== 3'b000 || jump_flag !== 1'b0 || jump_addr !== 32'h0 || flush !== 1'b0 || int_ack !== 1'b0 || halted !== 1'b0 || jrst_flag !== 1'b0) begin errors++; $display("FAIL ar_outputs got=%b/%b/%h/%b exp=000/0/0/0", hold_flag, jump_flag, jump_addr, flush); end
    next_cycle();
    ex_hold = 1'b0; rst_n = 1'b1; #1;
    checks++; if (jump_flag !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL ar_no_replay got=%b/%b exp=0/0", jump_flag, flush); end
    next_cycle(); #1;
    checks++; if (jump_flag !== 1'b0) begin errors++; $display("FAIL ar_no_replay2 got=%b exp=0", jump_flag); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_jump();
    test_hold_replay();
    test_int_vs_jump();
    test_halt_drain();
    test_jtag_reset();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
